// File: rtl/input_mux_sequencer.sv
// Input tile sequencer for Input_MUX_REG: fetches buffer words, steps the 2b phase, tracks sorted_valid.
// Optional INPUT_SEQ_PREFETCH_EN adds a holding register so the next word is read during the current one.
module input_mux_sequencer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_bitwidth,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_words,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [31:0]       buf_rdata,
  output logic [31:0]       mux_buffer,
  output logic [1:0]        mux_state,
  output logic [1:0]        mux_bitwidth,
  output logic              sorted_valid,
  input  logic              pe_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num, r_idx, w_idx_nxt;
  logic [1:0]        r_bw, r_phase, w_phase_nxt;
  logic [31:0]       r_buf, w_buf_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_done, w_done_nxt;
  logic              w_latch;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic              w_can_go, w_fire, w_last_ph, w_last_word;

  function automatic logic [1:0] f_last_phase(input logic [1:0] bw);
    case (bw)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // The consumer is free unless an output is being presented and refused.
  assign w_can_go    = !r_vld || pe_ready;
  assign w_fire      = (r_state == S_ISSUE) && w_can_go;
  assign w_last_ph   = (r_phase == f_last_phase(r_bw));
  assign w_last_word = (r_idx == (r_num - CNT_W'(1)));

`ifdef INPUT_SEQ_PREFETCH_EN
  logic        r_rd_pend, r_hold_vld, w_consume, w_avail;
  logic [31:0] r_hold, w_next_word;

  assign w_avail     = r_hold_vld || r_rd_pend;
  assign w_next_word = r_rd_pend ? buf_rdata : r_hold;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_buf_nxt   = r_buf;
    w_vld_nxt   = r_vld && !pe_ready;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_rd_en     = 1'b0;
    w_addr      = '0;
`ifdef INPUT_SEQ_PREFETCH_EN
    w_consume   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_idx_nxt   = '0;
          w_phase_nxt = 2'd0;
          if (cfg_num_words == '0) w_done_nxt = 1'b1;
          else                     w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // Hold off the read so the WAIT capture never lands on a refused output.
        if (w_can_go) begin
          w_rd_en     = 1'b1;
          w_addr      = r_base + ADDR_W'(r_idx);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef INPUT_SEQ_PREFETCH_EN
        if (w_avail && w_can_go) begin
          w_buf_nxt   = w_next_word;
          w_consume   = 1'b1;
          w_phase_nxt = 2'd0;
          w_state_nxt = S_ISSUE;
        end
`else
        w_buf_nxt   = buf_rdata;
        w_phase_nxt = 2'd0;
        w_state_nxt = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        if (w_fire) begin
          w_vld_nxt = 1'b1;
`ifdef INPUT_SEQ_PREFETCH_EN
          if ((r_phase == 2'd0) && !w_last_word) begin
            w_rd_en = 1'b1;
            w_addr  = r_base + ADDR_W'(r_idx) + ADDR_W'(1);
          end
`endif
          if (!w_last_ph) begin
            w_phase_nxt = r_phase + 2'd1;
          end else begin
            w_phase_nxt = 2'd0;
            if (w_last_word) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_idx_nxt = r_idx + CNT_W'(1);
`ifdef INPUT_SEQ_PREFETCH_EN
              // Single-phase words fire before their prefetch returns; WAIT picks it up.
              if (w_avail) begin
                w_buf_nxt = w_next_word;
                w_consume = 1'b1;
              end else begin
                w_state_nxt = S_WAIT;
              end
`else
              w_state_nxt = S_FETCH;
`endif
            end
          end
        end
      end
      S_DRAIN: begin
        if (w_can_go) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_num   <= '0;
      r_bw    <= 2'd0;
      r_idx   <= '0;
      r_phase <= 2'd0;
      r_buf   <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
      r_buf   <= w_buf_nxt;
      r_vld   <= w_vld_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_bw   <= cfg_bitwidth;
        r_base <= cfg_base_addr;
        r_num  <= cfg_num_words;
      end
    end
  end

`ifdef INPUT_SEQ_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_hold_vld <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_consume)      r_hold_vld <= 1'b0;
      else if (r_rd_pend) r_hold_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_pend && !w_consume) r_hold <= buf_rdata;
  end
`endif

  assign buf_rd_en    = w_rd_en;
  assign buf_addr     = w_addr;
  assign mux_buffer   = r_buf;
  assign mux_state    = r_phase;
  assign mux_bitwidth = r_bw;
  assign sorted_valid = r_vld;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;

endmodule

// File: tb/tb_input_mux_sequencer.sv
// Directed bench for input_mux_sequencer: buffer model, MUX_REG output model, accepted-phase log.
module tb_input_mux_sequencer;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;
`ifdef INPUT_SEQ_PREFETCH_EN
  localparam int GAP8  = 2;
  localparam int SPAN2 = 15;
`else
  localparam int GAP8  = 3;
  localparam int SPAN2 = 21;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        cfg_bitwidth = 2'd0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [CNT_W-1:0]  cfg_num_words = '0;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_rdata = '0;
  logic [31:0]       mux_buffer;
  logic [1:0]        mux_state;
  logic [1:0]        mux_bitwidth;
  logic              sorted_valid;
  logic              pe_ready = 1'b1;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  input_mux_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_bitwidth(cfg_bitwidth), .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .mux_buffer(mux_buffer), .mux_state(mux_state), .mux_bitwidth(mux_bitwidth),
    .sorted_valid(sorted_valid), .pe_ready(pe_ready), .busy(busy), .done(done)
  );

  function automatic logic [31:0] memf(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  always @(posedge clk) if (buf_rd_en) buf_rdata <= memf(buf_addr);

  // MUX_REG output register: reloads unless a presented output is refused.
  logic [31:0] mr_buf = '0;
  logic [1:0]  mr_st = 2'd0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] rd_q[$];
  logic [31:0] accb_q[$];
  logic [1:0]  accs_q[$];
  int          accc_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (buf_rd_en) rd_q.push_back(32'(buf_addr));
    if (sorted_valid && pe_ready) begin
      accb_q.push_back(mr_buf);
      accs_q.push_back(mr_st);
      accc_q.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (!sorted_valid || pe_ready) begin
      mr_buf <= mux_buffer;
      mr_st  <= mux_state;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int rb, ab, db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    rb = rd_q.size();
    ab = accb_q.size();
    db = done_cnt;
  endtask

  task automatic drive_start(input logic [1:0] bw, input logic [9:0] base, input logic [9:0] num);
    @(posedge clk); #1;
    start = 1'b1; cfg_bitwidth = bw; cfg_base_addr = base; cfg_num_words = num;
    @(posedge clk); #1;
    start = 1'b0; cfg_bitwidth = 2'd0; cfg_base_addr = '0; cfg_num_words = '0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_tile(input string tag, input logic [9:0] base, input int nw, input int nph);
    logic [9:0] a;
    chk({tag, "_nreads"}, 32'(rd_q.size() - rb), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      a = base + 10'(i);
      chk($sformatf("%s_rd%0d", tag, i), rd_q[rb + i], 32'(a));
    end
    chk({tag, "_naccepts"}, 32'(accb_q.size() - ab), 32'(nw * nph));
    for (int i = 0; i < nw * nph; i++) begin
      a = base + 10'(i / nph);
      chk($sformatf("%s_st%0d", tag, i), 32'(accs_q[ab + i]), 32'(i % nph));
      chk($sformatf("%s_buf%0d", tag, i), accb_q[ab + i], memf(a));
    end
    chk({tag, "_ndone"}, 32'(done_cnt - db), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_addr", 32'(buf_addr), 32'd0);
    chk("rst_buffer", mux_buffer, 32'd0);
    chk("rst_state", 32'(mux_state), 32'd0);
    chk("rst_bitwidth", 32'(mux_bitwidth), 32'd0);
    chk("rst_valid", 32'(sorted_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 8b, three words
    mark();
    drive_start(2'b00, 10'h010, 10'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 100);
    check_tile("t1", 10'h010, 3, 1);
    chk("t1_gap", 32'(accc_q[ab + 1] - accc_q[ab]), 32'(GAP8));

    // 4b, two words
    mark();
    drive_start(2'b01, 10'h100, 10'd2);
    wait_done("t2", 100);
    check_tile("t2", 10'h100, 2, 2);
    chk("t2_bitwidth", 32'(mux_bitwidth), 32'd1);

    // 2b, one word, consumer stalls while phase 1 is presented
    mark();
    drive_start(2'b10, 10'h020, 10'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sorted_valid && (mux_state == 2'd1)) begin ok = 1'b1; break; end
    end
    chk("t3_found_ph1", 32'(ok), 32'd1);
    @(posedge clk); #1 pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_vld%0d", i), 32'(sorted_valid), 32'd1);
      chk($sformatf("t3_hold_st%0d", i), 32'(mux_state), 32'd2);
      chk($sformatf("t3_hold_buf%0d", i), mux_buffer, memf(10'h020));
    end
    @(posedge clk); #1 pe_ready = 1'b1;
    wait_done("t3", 100);
    check_tile("t3", 10'h020, 1, 4);
    chk("t3_bitwidth", 32'(mux_bitwidth), 32'd2);

    // Address wrap at the top of the buffer
    mark();
    drive_start(2'b00, 10'h3FF, 10'd2);
    wait_done("t4", 100);
    check_tile("t4", 10'h3FF, 2, 1);

    // Empty tile
    mark();
    drive_start(2'b10, 10'h123, 10'd0);
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_done_once", 32'(done), 32'd0);
    chk("t5_nreads", 32'(rd_q.size() - rb), 32'd0);
    chk("t5_naccepts", 32'(accb_q.size() - ab), 32'd0);

    // Reset while phase 2 is presented, then a fresh tile
    mark();
    drive_start(2'b10, 10'h080, 10'd2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && (mux_state == 2'd2)) begin ok = 1'b1; break; end
    end
    chk("t6_found_ph2", 32'(ok), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rd_en", 32'(buf_rd_en), 32'd0);
    chk("t6_addr", 32'(buf_addr), 32'd0);
    chk("t6_buffer", mux_buffer, 32'd0);
    chk("t6_state", 32'(mux_state), 32'd0);
    chk("t6_bitwidth", 32'(mux_bitwidth), 32'd0);
    chk("t6_valid", 32'(sorted_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - db), 32'd0);
    mark();
    drive_start(2'b00, 10'h005, 10'd1);
    wait_done("t6r", 100);
    check_tile("t6r", 10'h005, 1, 1);

    // 2b, four words, consumer always ready
    mark();
    drive_start(2'b10, 10'h040, 10'd4);
    wait_done("t7", 200);
    check_tile("t7", 10'h040, 4, 4);
    chk("t7_span", 32'(accc_q[ab + 15] - accc_q[ab]), 32'(SPAN2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
